// File: rtl/pio_mem_arb_if.sv
// Client- and memory-side signal bundle for pio_mem_arb.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface pio_mem_arb_if #(
    parameter int unsigned WIDTH       = 20,
    parameter int unsigned DEPTH_NBITS = 10,
    parameter int unsigned NUM_RD      = 4
);
    logic                          init_start;
    logic                          init_done;
    logic [NUM_RD-1:0]             rd_req;
    logic [NUM_RD*DEPTH_NBITS-1:0] rd_addr;
    logic [NUM_RD-1:0]             rd_gnt;
    logic [NUM_RD-1:0]             rd_ack;
    logic [WIDTH-1:0]              rd_data;
    logic                          wr_req;
    logic [DEPTH_NBITS-1:0]        wr_addr;
    logic [WIDTH-1:0]              wr_data;
    logic                          wr_gnt;
    logic                          app_mem_rd;
    logic [DEPTH_NBITS-1:0]        app_mem_raddr;
    logic                          app_mem_wr;
    logic [DEPTH_NBITS-1:0]        app_mem_waddr;
    logic [WIDTH-1:0]              app_mem_wdata;
    logic                          app_mem_ack;
    logic [WIDTH-1:0]              app_mem_rdata;

    modport slave (
        input  init_start, rd_req, rd_addr, wr_req, wr_addr, wr_data,
               app_mem_ack, app_mem_rdata,
        output init_done, rd_gnt, rd_ack, rd_data, wr_gnt,
               app_mem_rd, app_mem_raddr, app_mem_wr, app_mem_waddr, app_mem_wdata
    );

    modport master (
        output init_start, rd_req, rd_addr, wr_req, wr_addr, wr_data,
               app_mem_ack, app_mem_rdata,
        input  init_done, rd_gnt, rd_ack, rd_data, wr_gnt,
               app_mem_rd, app_mem_raddr, app_mem_wr, app_mem_waddr, app_mem_wdata
    );
endinterface

// File: rtl/pio_mem_arb.sv
// BRAM access controller: clears memory to INIT_VALUE, round-robins NUM_RD readers onto
// the single read port, passes one writer through and holds off reads racing in-flight writes.
module pio_mem_arb #(
    parameter int unsigned          WIDTH       = 20,
    parameter int unsigned          DEPTH_NBITS = 10,
    parameter int unsigned          NUM_RD      = 4,
    parameter logic [WIDTH-1:0]     INIT_VALUE  = '0
) (
    input  logic          clk,
    input  logic          rst,
    pio_mem_arb_if.slave  bus
);
    localparam int unsigned ID_W = $clog2(NUM_RD);
    localparam logic [DEPTH_NBITS-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

    state_t                 state;
    logic [DEPTH_NBITS-1:0] init_cnt;
    logic [ID_W-1:0]        last_gnt;
    logic [ID_W-1:0]        gnt_id_d1;
    logic                   gnt_v_d1;
    logic                   hz0_v, hz1_v;
    logic [DEPTH_NBITS-1:0] hz0_addr, hz1_addr;

    logic                   in_init_c, in_run_c;
    logic                   wr_gnt_c, mem_wr_c;
    logic [DEPTH_NBITS-1:0] waddr_c;
    logic [WIDTH-1:0]       wdata_c;
    logic [DEPTH_NBITS-1:0] req_addr [NUM_RD];
    logic [NUM_RD-1:0]      elig_c;
    logic [NUM_RD-1:0]      gnt_c;
    logic [ID_W-1:0]        gnt_id_c;
    logic                   found_c;

    // Init sequencer: one clear write per cycle; init_start restarts the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            init_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= INIT;
                    init_cnt <= '0;
                end
                INIT: begin
                    if (bus.init_start) begin
                        init_cnt <= '0;
                    end else if (init_cnt == LAST_ADDR) begin
                        state    <= RUN;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + DEPTH_NBITS'(1);
                    end
                end
                RUN: begin
                    if (bus.init_start) begin
                        state    <= INIT;
                        init_cnt <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    assign in_init_c = (state == INIT);
    assign in_run_c  = (state == RUN);
    assign wr_gnt_c  = bus.wr_req & in_run_c;
    assign mem_wr_c  = in_init_c | wr_gnt_c;
    assign waddr_c   = in_init_c ? init_cnt : bus.wr_addr;
    assign wdata_c   = in_init_c ? INIT_VALUE : bus.wr_data;

    // Writes land two cycles after issue; remember the last two so reads cannot overtake them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz0_v    <= 1'b0;
            hz0_addr <= '0;
            hz1_v    <= 1'b0;
            hz1_addr <= '0;
        end else begin
            hz0_v    <= mem_wr_c;
            hz0_addr <= waddr_c;
            hz1_v    <= hz0_v;
            hz1_addr <= hz0_addr;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_elig
        assign req_addr[i] = bus.rd_addr[i*DEPTH_NBITS +: DEPTH_NBITS];
        assign elig_c[i]   = bus.rd_req[i] & in_run_c
                           & ~((hz0_v    & (hz0_addr == req_addr[i]))
                             | (hz1_v    & (hz1_addr == req_addr[i]))
                             | (mem_wr_c & (waddr_c  == req_addr[i])));
    end

    // Round-robin pick starting one past the last winner.
    always_comb begin
        found_c  = 1'b0;
        gnt_id_c = '0;
        for (int k = 1; k <= int'(NUM_RD); k++) begin
            if (!found_c && elig_c[ID_W'((int'(last_gnt) + k) % int'(NUM_RD))]) begin
                found_c  = 1'b1;
                gnt_id_c = ID_W'((int'(last_gnt) + k) % int'(NUM_RD));
            end
        end
        gnt_c = found_c ? (NUM_RD'(1) << gnt_id_c) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt  <= ID_W'(NUM_RD - 1);
            gnt_v_d1  <= 1'b0;
            gnt_id_d1 <= '0;
        end else begin
            if (found_c) begin
                last_gnt <= gnt_id_c;
            end
            gnt_v_d1  <= found_c;
            gnt_id_d1 <= gnt_id_c;
        end
    end

    assign bus.init_done     = in_run_c;
    assign bus.wr_gnt        = wr_gnt_c;
    assign bus.rd_gnt        = gnt_c;
    assign bus.app_mem_rd    = found_c;
    assign bus.app_mem_raddr = req_addr[gnt_id_c];
    assign bus.app_mem_wr    = mem_wr_c;
    assign bus.app_mem_waddr = waddr_c;
    assign bus.app_mem_wdata = wdata_c;
    assign bus.rd_ack        = (NUM_RD'(1) << gnt_id_d1)
                             & {NUM_RD{bus.app_mem_ack & gnt_v_d1}};
    assign bus.rd_data       = bus.app_mem_rdata;
endmodule

// File: tb/tb_pio_mem_arb.sv
// Directed bench for pio_mem_arb with a BRAM model: 1-cycle read latency, writes land 2 cycles late.
module tb_pio_mem_arb;
    localparam int unsigned WIDTH       = 20;
    localparam int unsigned DEPTH_NBITS = 4;
    localparam int unsigned NUM_RD      = 4;
    localparam int unsigned DEPTH       = 1 << DEPTH_NBITS;
    localparam logic [WIDTH-1:0] INIT_VAL = 20'h5A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    pio_mem_arb_if #(.WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS), .NUM_RD(NUM_RD)) bus ();

    pio_mem_arb #(
        .WIDTH(WIDTH), .DEPTH_NBITS(DEPTH_NBITS), .NUM_RD(NUM_RD), .INIT_VALUE(INIT_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model
    logic [WIDTH-1:0]       mem [DEPTH];
    logic                   w1_v = 1'b0, w2_v = 1'b0;
    logic [DEPTH_NBITS-1:0] w1_a = '0, w2_a = '0;
    logic [WIDTH-1:0]       w1_d = '0, w2_d = '0;
    logic                   ack_q = 1'b0;
    logic [WIDTH-1:0]       rdata_q = '0;

    always @(posedge clk) begin
        w1_v <= bus.app_mem_wr;
        w1_a <= bus.app_mem_waddr;
        w1_d <= bus.app_mem_wdata;
        w2_v <= w1_v;
        w2_a <= w1_a;
        w2_d <= w1_d;
        if (w2_v) mem[w2_a] <= w2_d;
        ack_q   <= bus.app_mem_rd;
        rdata_q <= mem[bus.app_mem_raddr];
    end

    assign bus.app_mem_ack   = ack_q;
    assign bus.app_mem_rdata = rdata_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [DEPTH_NBITS-1:0] a);
        bus.rd_addr[i*DEPTH_NBITS +: DEPTH_NBITS] = a;
    endtask

    task automatic clr_in();
        bus.init_start = 1'b0;
        bus.rd_req     = '0;
        bus.rd_addr    = '0;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_init_done"}, 32'(bus.init_done), 0);
        chk({tag, "_rd_gnt"},    32'(bus.rd_gnt),    0);
        chk({tag, "_rd_ack"},    32'(bus.rd_ack),    0);
        chk({tag, "_wr_gnt"},    32'(bus.wr_gnt),    0);
        chk({tag, "_mem_rd"},    32'(bus.app_mem_rd), 0);
        chk({tag, "_mem_wr"},    32'(bus.app_mem_wr), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_in();
        // Reset with live requests: nothing may be granted
        bus.rd_req = '1;
        bus.wr_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst");
        clr_in();

        // Release: cycle 0 is IDLE, cycles 1..16 clear the memory
        rst = 1'b0;
        #1;
        chk("idle_mem_wr", 32'(bus.app_mem_wr), 0);
        chk("idle_init_done", 32'(bus.init_done), 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick(); #1;
            chk("init_wr", 32'(bus.app_mem_wr), 1);
            chk("init_waddr", 32'(bus.app_mem_waddr), 32'(i));
            chk("init_wdata", 32'(bus.app_mem_wdata), 32'(INIT_VAL));
            chk("init_done_low", 32'(bus.init_done), 0);
        end

        // Cycle 17: RUN; read of last-cleared address held off two cycles
        tick();
        bus.rd_req = 4'b1000; set_addr(3, 4'd15);
        #1;
        chk("run_init_done", 32'(bus.init_done), 1);
        chk("run_mem_wr", 32'(bus.app_mem_wr), 0);
        chk("last_hz_gnt0", 32'(bus.rd_gnt), 0);
        tick(); #1;
        chk("last_hz_gnt1", 32'(bus.rd_gnt), 0);
        tick(); #1;
        chk("last_gnt", 32'(bus.rd_gnt), 32'h8);
        chk("last_raddr", 32'(bus.app_mem_raddr), 15);
        tick(); bus.rd_req = '0; #1;
        chk("last_ack", 32'(bus.rd_ack), 32'h8);
        chk("last_data", 32'(bus.rd_data), 32'(INIT_VAL));

        // Round-robin with all requesters held
        tick();
        bus.rd_req = '1;
        for (int i = 0; i < int'(NUM_RD); i++) set_addr(i, 4'(i));
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin tick(); #1; end
            chk("rr_gnt", 32'(bus.rd_gnt), 32'(1 << (c % 4)));
            chk("rr_raddr", 32'(bus.app_mem_raddr), 32'(c % 4));
            if (c > 0) begin
                chk("rr_ack", 32'(bus.rd_ack), 32'(1 << ((c - 1) % 4)));
                chk("rr_data", 32'(bus.rd_data), 32'(INIT_VAL));
            end else begin
                chk("rr_ack0", 32'(bus.rd_ack), 0);
            end
        end
        tick(); bus.rd_req = '0; #1;
        chk("rr_ack_last", 32'(bus.rd_ack), 32'h8);

        // Write to 7 at T; reader 1 on 7 held until T+3, reader 2 on 3 granted at T
        tick();
        bus.wr_req = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 20'h12345;
        bus.rd_req = 4'b0110; set_addr(1, 4'd7); set_addr(2, 4'd3);
        #1;
        chk("wr_gnt", 32'(bus.wr_gnt), 1);
        chk("wr_mem_wr", 32'(bus.app_mem_wr), 1);
        chk("wr_waddr", 32'(bus.app_mem_waddr), 7);
        chk("wr_wdata", 32'(bus.app_mem_wdata), 32'h12345);
        chk("haz_t0_gnt", 32'(bus.rd_gnt), 32'h4);
        chk("haz_t0_raddr", 32'(bus.app_mem_raddr), 3);
        tick(); bus.wr_req = 1'b0; bus.rd_req = 4'b0010; #1;
        chk("haz_t1_wr_gnt", 32'(bus.wr_gnt), 0);
        chk("haz_t1_gnt", 32'(bus.rd_gnt), 0);
        chk("haz_t1_ack", 32'(bus.rd_ack), 32'h4);
        chk("haz_t1_data", 32'(bus.rd_data), 32'(INIT_VAL));
        tick(); #1;
        chk("haz_t2_gnt", 32'(bus.rd_gnt), 0);
        tick(); #1;
        chk("haz_t3_gnt", 32'(bus.rd_gnt), 32'h2);
        chk("haz_t3_raddr", 32'(bus.app_mem_raddr), 7);
        tick(); bus.rd_req = '0; #1;
        chk("haz_t4_ack", 32'(bus.rd_ack), 32'h2);
        chk("haz_t4_data", 32'(bus.rd_data), 32'h12345);

        // Re-init with a read granted alongside init_start; requests during INIT wait
        tick();
        bus.init_start = 1'b1; bus.rd_req = 4'b1000; set_addr(3, 4'd4);
        #1;
        chk("ri_gnt", 32'(bus.rd_gnt), 32'h8);
        tick();
        bus.init_start = 1'b0; bus.rd_req = 4'b0001; set_addr(0, 4'd9);
        bus.wr_req = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 20'hABCDE;
        #1;
        chk("ri_init_done", 32'(bus.init_done), 0);
        chk("ri_ack_in_init", 32'(bus.rd_ack), 32'h8);
        chk("ri_ack_data", 32'(bus.rd_data), 32'(INIT_VAL));
        chk("ri_waddr0", 32'(bus.app_mem_waddr), 0);
        chk("ri_wr_gnt0", 32'(bus.wr_gnt), 0);
        for (int i = 1; i < int'(DEPTH); i++) begin
            tick(); #1;
            chk("ri_waddr", 32'(bus.app_mem_waddr), 32'(i));
            chk("ri_wr_gnt", 32'(bus.wr_gnt), 0);
            chk("ri_rd_gnt", 32'(bus.rd_gnt), 0);
        end
        tick(); #1;
        chk("ri_run", 32'(bus.init_done), 1);
        chk("ri_wr_gnt_run", 32'(bus.wr_gnt), 1);
        chk("ri_wr_waddr", 32'(bus.app_mem_waddr), 9);
        chk("ri_wr_wdata", 32'(bus.app_mem_wdata), 32'hABCDE);
        chk("ri_rd_held0", 32'(bus.rd_gnt), 0);
        tick(); bus.wr_req = 1'b0; #1;
        chk("ri_rd_held1", 32'(bus.rd_gnt), 0);
        tick(); #1;
        chk("ri_rd_held2", 32'(bus.rd_gnt), 0);
        tick(); #1;
        chk("ri_rd_gnt_ok", 32'(bus.rd_gnt), 32'h1);
        tick(); bus.rd_req = '0; #1;
        chk("ri_rd_ack", 32'(bus.rd_ack), 32'h1);
        chk("ri_rd_data", 32'(bus.rd_data), 32'hABCDE);

        // Read granted the cycle before init_start, then restart at count 5
        tick(); bus.rd_req = 4'b0100; set_addr(2, 4'd9); #1;
        chk("rs_gnt", 32'(bus.rd_gnt), 32'h4);
        tick(); bus.rd_req = '0; bus.init_start = 1'b1; #1;
        chk("rs_ack", 32'(bus.rd_ack), 32'h4);
        chk("rs_data", 32'(bus.rd_data), 32'hABCDE);
        tick(); bus.init_start = 1'b0; #1;
        chk("rs_init_done", 32'(bus.init_done), 0);
        chk("rs_waddr0", 32'(bus.app_mem_waddr), 0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 5) bus.init_start = 1'b1;
            #1;
            chk("rs_pre_waddr", 32'(bus.app_mem_waddr), 32'(i));
        end
        tick(); bus.init_start = 1'b0; #1;
        chk("rs_restart_wr", 32'(bus.app_mem_wr), 1);
        chk("rs_restart_waddr", 32'(bus.app_mem_waddr), 0);
        for (int i = 1; i < int'(DEPTH); i++) begin
            tick(); #1;
            chk("rs_waddr", 32'(bus.app_mem_waddr), 32'(i));
            chk("rs_done_low", 32'(bus.init_done), 0);
        end
        tick(); bus.rd_req = 4'b0001; set_addr(0, 4'd9); #1;
        chk("rs_run", 32'(bus.init_done), 1);
        chk("rs_rd_gnt", 32'(bus.rd_gnt), 32'h1);
        tick(); bus.rd_req = '0; #1;
        chk("rs_cleared", 32'(bus.rd_data), 32'(INIT_VAL));
        chk("rs_cleared_ack", 32'(bus.rd_ack), 32'h1);

        // Reset during a read burst
        tick();
        bus.rd_req = '1;
        for (int i = 0; i < int'(NUM_RD); i++) set_addr(i, 4'(i));
        #1;
        chk("rb_gnt0", 32'(bus.rd_gnt), 32'h2);
        tick(); #1;
        chk("rb_gnt1", 32'(bus.rd_gnt), 32'h4);
        chk("rb_ack1", 32'(bus.rd_ack), 32'h2);
        tick(); #1;
        chk("rb_ack2", 32'(bus.rd_ack), 32'h4);
        bus.wr_req = 1'b1;
        rst = 1'b1;
        #1;
        chk_all_zero("rb_rst");
        tick(); tick();
        rst = 1'b0; bus.wr_req = 1'b0;
        #1;
        chk("rb_idle_ack", 32'(bus.rd_ack), 0);
        chk("rb_idle_gnt", 32'(bus.rd_gnt), 0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick(); #1;
            chk("rb_init_gnt", 32'(bus.rd_gnt), 0);
            chk("rb_init_ack", 32'(bus.rd_ack), 0);
        end
        tick(); #1;
        chk("rb_run", 32'(bus.init_done), 1);
        chk("rb_restart_gnt", 32'(bus.rd_gnt), 32'h1);
        chk("rb_restart_raddr", 32'(bus.app_mem_raddr), 0);
        tick(); bus.rd_req = '0; #1;
        chk("rb_restart_ack", 32'(bus.rd_ack), 32'h1);
        chk("rb_restart_data", 32'(bus.rd_data), 32'(INIT_VAL));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
